// File: rtl/pc_call_stack.sv
// Program counter with a hardware call/return stack for the convolution RISC core.
// All state changes happen on the rising clk edge. Every output comes straight from a flop.
module pc_call_stack #(
    parameter int unsigned AW         = 9,
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       complete,
    input  logic                       inc,
    input  logic                       w_en,
    input  logic                       br_en,
    input  logic [DW-1:0]              br_off,
    input  logic                       call,
    input  logic                       ret,
    input  logic [DW-1:0]              data_in,
    output logic [AW-1:0]              instruction_address,
    output logic                       running,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] stack_level,
    output logic                       stack_ovf,
    output logic                       stack_unf
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Architectural state
    logic [AW-1:0] pc_q,      pc_d;
    logic          running_q, running_d;
    logic          halted_q,  halted_d;
    logic [LW-1:0] level_q,   level_d;
    logic          ovf_q,     ovf_d;
    logic          unf_q,     unf_d;

    // Return-address storage. It is deliberately left without a reset; level_q decides what is valid.
    logic [AW-1:0] stack_mem [DEPTH];

    // Datapath helpers
    logic [AW-1:0] pc_inc_c;
    logic [AW-1:0] target_c;
    logic [AW-1:0] br_sum_c;
    logic [AW-1:0] pop_data_c;
    logic [PW-1:0] push_idx_c;
    logic [PW-1:0] pop_idx_c;
    logic          can_push_c;
    logic          can_pop_c;
    logic          stack_we_c;

    // Only the low AW bits of the wide operands drive the PC.
    generate
        if (DW > AW) begin : g_hi_bits
            logic unused_hi;
            assign unused_hi = ^{data_in[DW-1:AW], br_off[DW-1:AW]};
        end
    endgenerate

    // Address arithmetic. Every sum wraps modulo 2^AW.
    always_comb begin
        pc_inc_c   = pc_q + AW'(1);
        target_c   = data_in[AW-1:0];
        br_sum_c   = pc_q + br_off[AW-1:0];
        can_pop_c  = (level_q != '0);
        can_push_c = (level_q < LW'(DEPTH));
        push_idx_c = PW'(level_q);
        pop_idx_c  = can_pop_c ? PW'(level_q - LW'(1)) : '0;
        pop_data_c = stack_mem[pop_idx_c];
    end

    // Next-state logic: latch the start request, then apply one prioritised action per edge.
    always_comb begin
        pc_d       = pc_q;
        running_d  = running_q;
        halted_d   = halted_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        stack_we_c = 1'b0;

        if (!running_q) begin
            if (en) begin
                running_d = 1'b1;
            end
        end else if (!halted_q) begin
            if (complete) begin
                halted_d = 1'b1;
            end else if (ret) begin
                // A simultaneous call is dropped.
                if (can_pop_c) begin
                    pc_d    = pop_data_c;
                    level_d = level_q - LW'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end else if (call) begin
                // A call into a full stack neither pushes nor jumps.
                if (can_push_c) begin
                    stack_we_c = 1'b1;
                    level_d    = level_q + LW'(1);
                    pc_d       = target_c;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (w_en) begin
                pc_d = target_c;
            end else if (br_en) begin
                pc_d = br_sum_c;
            end else if (inc) begin
                pc_d = pc_inc_c;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= AW'(RESET_ADDR);
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            running_q <= running_d;
            halted_q  <= halted_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Stack write: store the return address (PC+1, wrapped) at the current top.
    always_ff @(posedge clk) begin
        if (stack_we_c) begin
            stack_mem[push_idx_c] <= pc_inc_c;
        end
    end

    // Outputs come straight from the state flops.
    assign instruction_address = pc_q;
    assign running             = running_q;
    assign halted              = halted_q;
    assign stack_level         = level_q;
    assign stack_ovf           = ovf_q;
    assign stack_unf           = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack. It uses a directed vector table, hand-written corner
// sequences and a randomized phase. All of them are compared against a queue-based reference model.
module tb_pc_call_stack;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int MASK  = (1 << AW) - 1;

    // Strobe masks: {en, complete, inc, w_en, br_en, call, ret}
    localparam logic [6:0] E  = 7'b1000000;
    localparam logic [6:0] C  = 7'b0100000;
    localparam logic [6:0] I  = 7'b0010000;
    localparam logic [6:0] W  = 7'b0001000;
    localparam logic [6:0] B  = 7'b0000100;
    localparam logic [6:0] CL = 7'b0000010;
    localparam logic [6:0] R  = 7'b0000001;

    typedef struct {
        bit          en, complete, inc, w_en, br_en, call, ret;
        logic [31:0] data;
        logic [31:0] boff;
    } ops_t;

    typedef struct {
        ops_t op;
        int   exp_pc;
        int   exp_lvl;
        bit   exp_run, exp_halt, exp_ovf, exp_unf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en, complete, inc, w_en, br_en, call, ret;
    logic [DW-1:0] br_off, data_in;
    logic [AW-1:0] instruction_address;
    logic          running, halted, stack_ovf, stack_unf;
    logic [3:0]    stack_level;

    pc_call_stack #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .complete(complete), .inc(inc), .w_en(w_en),
        .br_en(br_en), .br_off(br_off), .call(call), .ret(ret), .data_in(data_in),
        .instruction_address(instruction_address), .running(running), .halted(halted),
        .stack_level(stack_level), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc;
    int m_q[$];
    bit m_run, m_halt, m_ovf, m_unf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic ops_t mk(input logic [6:0] m, input logic [31:0] val);
        ops_t o;
        {o.en, o.complete, o.inc, o.w_en, o.br_en, o.call, o.ret} = m;
        o.data = val;
        o.boff = val;
        return o;
    endfunction

    task automatic drive(input ops_t o);
        en = o.en; complete = o.complete; inc = o.inc; w_en = o.w_en;
        br_en = o.br_en; call = o.call; ret = o.ret; data_in = o.data; br_off = o.boff;
    endtask

    task automatic model_reset();
        m_pc = 0; m_q.delete(); m_run = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
    endtask

    // One clock of the documented behaviour: the first enable only starts the core, then one action per edge.
    task automatic model_step(input ops_t o);
        if (!m_run) begin
            if (o.en) m_run = 1;
        end else if (!m_halt) begin
            if (o.complete) m_halt = 1;
            else if (o.ret) begin
                if (m_q.size() > 0) m_pc = m_q.pop_back();
                else m_unf = 1;
            end else if (o.call) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back((m_pc + 1) & MASK);
                    m_pc = int'(o.data) & MASK;
                end else m_ovf = 1;
            end else if (o.w_en)  m_pc = int'(o.data) & MASK;
            else if (o.br_en)     m_pc = (m_pc + int'(o.boff)) & MASK;
            else if (o.inc)       m_pc = (m_pc + 1) & MASK;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " pc"},   int'(instruction_address), m_pc);
        chk({tag, " lvl"},  int'(stack_level), m_q.size());
        chk({tag, " run"},  int'(running), int'(m_run));
        chk({tag, " halt"}, int'(halted), int'(m_halt));
        chk({tag, " ovf"},  int'(stack_ovf), int'(m_ovf));
        chk({tag, " unf"},  int'(stack_unf), int'(m_unf));
    endtask

    // Drive at a falling edge, let the rising edge act, and compare at the next falling edge.
    task automatic step(input ops_t o, input string tag);
        drive(o);
        @(negedge clk);
        model_step(o);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(mk(7'b0, 32'h0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t vecs[18];

    initial begin
        ops_t o;
        vecs[0]  = '{mk(E, 0),              0,     0, 1, 0, 0, 0};
        vecs[1]  = '{mk(I, 0),              1,     0, 1, 0, 0, 0};
        vecs[2]  = '{mk(I, 0),              2,     0, 1, 0, 0, 0};
        vecs[3]  = '{mk(I, 0),              3,     0, 1, 0, 0, 0};
        vecs[4]  = '{mk(W, 32'h10),         'h10,  0, 1, 0, 0, 0};
        vecs[5]  = '{mk(CL, 32'h80),        'h80,  1, 1, 0, 0, 0};
        vecs[6]  = '{mk(R, 0),              'h11,  0, 1, 0, 0, 0};
        vecs[7]  = '{mk(W, 32'h1FF),        'h1FF, 0, 1, 0, 0, 0};
        vecs[8]  = '{mk(I, 0),              0,     0, 1, 0, 0, 0};
        vecs[9]  = '{mk(W, 32'h5),          5,     0, 1, 0, 0, 0};
        vecs[10] = '{mk(B, 32'hFFFF_FFF8),  'h1FD, 0, 1, 0, 0, 0};
        vecs[11] = '{mk(CL | R, 32'h40),    'h1FD, 0, 1, 0, 0, 1};
        vecs[12] = '{mk(B, 32'h3),          0,     0, 1, 0, 0, 1};
        vecs[13] = '{mk(W | I, 32'h33),     'h33,  0, 1, 0, 0, 1};
        vecs[14] = '{mk(B | I, 32'h2),      'h35,  0, 1, 0, 0, 1};
        vecs[15] = '{mk(CL | W, 32'h100),   'h100, 1, 1, 0, 0, 1};
        vecs[16] = '{mk(R | I, 0),          'h36,  0, 1, 0, 0, 1};
        vecs[17] = '{mk(E | I, 0),          'h37,  0, 1, 0, 0, 1};

        do_reset();
        check_model("reset");

        // While en has never been seen, inc strobes are ignored.
        for (int i = 0; i < 5; i++) step(mk(I, 0), "idle");
        chk("idle pc", int'(instruction_address), 0);
        chk("idle run", int'(running), 0);

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].op, $sformatf("vec%0d mdl", i));
            chk($sformatf("vec%0d pc", i),   int'(instruction_address), vecs[i].exp_pc);
            chk($sformatf("vec%0d lvl", i),  int'(stack_level), vecs[i].exp_lvl);
            chk($sformatf("vec%0d run", i),  int'(running), int'(vecs[i].exp_run));
            chk($sformatf("vec%0d halt", i), int'(halted), int'(vecs[i].exp_halt));
            chk($sformatf("vec%0d ovf", i),  int'(stack_ovf), int'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d unf", i),  int'(stack_unf), int'(vecs[i].exp_unf));
        end

        // Nested calls past the stack depth, then unwinding past empty
        do_reset();
        step(mk(E, 0), "t4 en");
        for (int i = 0; i < 9; i++) begin
            step(mk(CL, 32'(32'h100 + i * 8)), "t4 call");
            chk("t4 call lvl", int'(stack_level), (i < DEPTH) ? i + 1 : DEPTH);
        end
        chk("t4 full pc", int'(instruction_address), 'h138);
        chk("t4 ovf", int'(stack_ovf), 1);
        for (int j = 0; j < 9; j++) begin
            step(mk(R, 0), "t4 ret");
            chk("t4 ret pc", int'(instruction_address), (j < 7) ? ('h100 + (6 - j) * 8 + 1) : 1);
            chk("t4 ret lvl", int'(stack_level), (j < 8) ? 7 - j : 0);
        end
        chk("t4 unf", int'(stack_unf), 1);

        // complete beats every other strobe, and the PC stays frozen afterwards
        do_reset();
        step(mk(E, 0), "t5 en");
        step(mk(W, 32'h20), "t5 w");
        step(mk(CL, 32'h50), "t5 call");
        step(mk(C | I | CL | R, 32'h99), "t5 cmp");
        chk("t5 cmp pc", int'(instruction_address), 'h50);
        chk("t5 cmp lvl", int'(stack_level), 1);
        chk("t5 halted", int'(halted), 1);
        step(mk(I, 0), "t5 inc");
        chk("t5 frozen pc", int'(instruction_address), 'h50);
        step(mk(R, 0), "t5 ret");
        chk("t5 frozen lvl", int'(stack_level), 1);

        // Asynchronous reset in the middle of a cycle
        do_reset();
        step(mk(E, 0), "t6 en");
        step(mk(R, 0), "t6 unf");
        step(mk(CL, 32'h20), "t6 c1");
        drive(mk(CL, 32'h40));
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async pc", int'(instruction_address), 0);
        chk("t6 async lvl", int'(stack_level), 0);
        chk("t6 async run", int'(running), 0);
        chk("t6 async unf", int'(stack_unf), 0);
        drive(mk(7'b0, 0));
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        step(mk(I, 0), "t6 noen");
        chk("t6 noen pc", int'(instruction_address), 0);
        step(mk(E, 0), "t6 en2");
        step(mk(I, 0), "t6 inc");
        chk("t6 inc pc", int'(instruction_address), 1);

        // Randomized episodes against the reference model
        for (int ep = 0; ep < 3; ep++) begin
            do_reset();
            step(mk(E, 0), "rnd en");
            for (int n = 0; n < 400; n++) begin
                o.en       = $urandom_range(0, 1) == 1;
                o.complete = $urandom_range(0, 299) == 0;
                o.inc      = $urandom_range(0, 1) == 1;
                o.w_en     = $urandom_range(0, 9) == 0;
                o.br_en    = $urandom_range(0, 6) == 0;
                o.call     = $urandom_range(0, 4) == 0;
                o.ret      = $urandom_range(0, 4) == 0;
                o.data     = $urandom;
                o.boff     = ($urandom_range(0, 1) == 1) ? 32'($signed(32'($urandom_range(0, 63))) - 32)
                                                         : 32'($urandom);
                step(o, $sformatf("rnd%0d.%0d", ep, n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
